// File: rtl/cpu_cycle_stretch.sv
// cpu_cycle_stretch: CPU and 1 MHz clock-enable generator that stretches 1 MHz accesses to end on a 1 MHz high phase
module cpu_cycle_stretch #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mhz1_enable,
  input  logic stretch_disable,
  output logic cpu_clken,
  output logic mhz1_clken,
  output logic phase_1m,
  output logic cpu_stall,
  output logic io_cycle_end
);
  localparam int W = $clog2(CLK_DIV);
  typedef enum logic [1:0] {S_RUN, S_HUNT, S_FINISH} state_t;
  if (CLK_DIV < 4 || CLK_DIV % 2 != 0) begin : g_bad_div
    $error("CLK_DIV must be even and >= 4");
  end
  state_t state, state_nx;
  logic [W-1:0] div_cnt;
  logic period_end, cycle_start;
  assign period_end  = div_cnt == W'(CLK_DIV - 1);
  assign cycle_start = div_cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      phase_1m <= 1'b0;
      state    <= S_RUN;
    end else begin
      div_cnt  <= period_end ? '0 : div_cnt + 1'b1;
      phase_1m <= phase_1m ^ period_end;
      state    <= state_nx;
    end
  end
  always_comb begin
    state_nx     = state == S_RUN    ? ((cycle_start && mhz1_enable && !stretch_disable) ? S_HUNT : S_RUN)
                 : state == S_HUNT   ? ((period_end && !phase_1m) ? S_FINISH : S_HUNT)
                 : state == S_FINISH ? (period_end ? S_RUN : S_FINISH)
                 : S_RUN;
    cpu_clken    = period_end && (state == S_RUN || state == S_FINISH);
    io_cycle_end = period_end && state == S_FINISH;
    mhz1_clken   = period_end && phase_1m;
    cpu_stall    = state != S_RUN;
  end
endmodule

// File: tb/tb_cpu_cycle_stretch.sv
// tb_cpu_cycle_stretch: scoreboard bench for cpu_cycle_stretch
module tb_cpu_cycle_stretch;
  localparam int N = 26;
  localparam logic [3:0] TBL [0:N-1] = '{
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h1, 4'h0, 4'h1,
    4'h5, 4'h5, 4'h5, 4'h4,
    4'h3, 4'h3, 4'h3, 4'h7,
    4'h1, 4'h0, 4'h9,
    4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0
  };
  typedef struct {int t; bit io;} ev_t;
  logic clk = 1'b0, reset = 1'b1, mhz1_enable = 1'b0, stretch_disable = 1'b0;
  logic cpu_clken, mhz1_clken, phase_1m, cpu_stall, io_cycle_end;
  int checks = 0, failures = 0;
  int t, next_start, cur_start, cur_end, rst_at, idx, guard;
  bit cur_str, noise;
  ev_t q[$];
  cpu_cycle_stretch #(.CLK_DIV(16)) dut (
    .clk(clk), .reset(reset), .mhz1_enable(mhz1_enable), .stretch_disable(stretch_disable),
    .cpu_clken(cpu_clken), .mhz1_clken(mhz1_clken), .phase_1m(phase_1m),
    .cpu_stall(cpu_stall), .io_cycle_end(io_cycle_end)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%b exp=%b", tag, t, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    mhz1_enable = 1'b0;
    stretch_disable = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_clken", cpu_clken, 1'b0);
    chk("rst_mhz1_clken", mhz1_clken, 1'b0);
    chk("rst_phase_1m", phase_1m, 1'b0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    chk("rst_io_cycle_end", io_cycle_end, 1'b0);
    reset = 1'b0;
    q.delete();
    t = 0;
    next_start = 0;
    cur_str = 1'b0;
    noise = 1'b0;
    rst_at = -1;
  endtask
  task automatic step();
    bit ec, eio;
    logic [3:0] e;
    int len;
    ec  = q.size() > 0 && q[0].t == t;
    eio = ec && q[0].io;
    chk("cpu_clken", cpu_clken, ec);
    chk("io_cycle_end", io_cycle_end, eio);
    chk("mhz1_clken", mhz1_clken, (t % 32) == 31);
    chk("phase_1m", phase_1m, ((t / 16) % 2) == 1);
    chk("cpu_stall", cpu_stall, cur_str && t > cur_start && t <= cur_end);
    if (ec) void'(q.pop_front());
    if (t == next_start) begin
      e = idx < N ? TBL[idx] : 4'h0;
      if (idx < N) idx++;
      mhz1_enable = e[0];
      stretch_disable = e[1];
      noise = e[2];
      cur_str = e[0] && !e[1];
      len = cur_str ? ((((t / 16) % 2) == 1) ? 48 : 32) : 16;
      cur_start = t;
      cur_end = t + len - 1;
      q.push_back('{cur_end, cur_str});
      next_start = t + len;
      rst_at = e[3] ? t + 5 : -1;
    end else begin
      mhz1_enable = noise ? 1'($urandom_range(1)) : 1'b0;
      stretch_disable = noise ? 1'($urandom_range(1)) : 1'b0;
    end
    @(negedge clk);
    t++;
  endtask
  initial begin
    idx = 0;
    guard = 0;
    do_reset();
    while (!(idx >= N && t == next_start) && guard < 5000) begin
      guard++;
      if (t == rst_at) do_reset();
      step();
    end
    chk("run_completed", guard < 5000, 1'b1);
    chk("scoreboard_empty", q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
